// File: rtl/bcd_count_monitor.sv
// Watches a BCD up/down counter and checks each qualified sample against the value
// predicted from the previous legal sample. It also counts errors and flags 9<->0 wraps.
module bcd_count_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic       x,
  input  logic       en,
  input  logic       clr_err,
  output logic       locked,
  output logic       err,
  output logic [3:0] err_cnt,
  output logic       wrap_up,
  output logic       wrap_dn,
  output logic [3:0] last
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] p_reg, p_next;
  logic       xp_reg, xp_next;
  logic [3:0] last_reg, last_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       wrap_up_reg, wrap_up_next;
  logic       wrap_dn_reg, wrap_dn_next;

  logic       legal;
  logic [3:0] expected;
  logic [3:0] cnt_inc;

  assign legal = (bcd <= 4'd9);

  always_comb begin
    if (xp_reg) expected = (p_reg == 4'd9) ? 4'd0 : 4'(p_reg + 4'd1);
    else        expected = (p_reg == 4'd0) ? 4'd9 : 4'(p_reg - 4'd1);
  end

  assign cnt_inc = (cnt_reg == 4'd15) ? cnt_reg : 4'(cnt_reg + 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= SYNC;
      p_reg       <= 4'd0;
      xp_reg      <= 1'b1;
      last_reg    <= 4'd0;
      cnt_reg     <= 4'd0;
      wrap_up_reg <= 1'b0;
      wrap_dn_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      p_reg       <= p_next;
      xp_reg      <= xp_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      wrap_up_reg <= wrap_up_next;
      wrap_dn_reg <= wrap_dn_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    p_next       = p_reg;
    xp_next      = xp_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    wrap_up_next = 1'b0;
    wrap_dn_next = 1'b0;
    // Clearing discards the sample on the same edge.
    if (clr_err) begin
      state_next = SYNC;
      cnt_next   = 4'd0;
    end else if (en) begin
      unique case (state_reg)
        SYNC: begin
          if (legal) begin
            p_next     = bcd;
            xp_next    = x;
            last_next  = bcd;
            state_next = TRACK;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        TRACK: begin
          if (legal && (bcd == expected)) begin
            p_next       = bcd;
            xp_next      = x;
            last_next    = bcd;
            wrap_up_next = xp_reg && (p_reg == 4'd9);
            wrap_dn_next = !xp_reg && (p_reg == 4'd0);
          end else begin
            state_next = ERR;
            cnt_next   = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    locked = (state_reg == TRACK);
    err    = (state_reg == ERR);
  end

  assign err_cnt = cnt_reg;
  assign wrap_up = wrap_up_reg;
  assign wrap_dn = wrap_dn_reg;
  assign last    = last_reg;

endmodule

// File: tb/tb_bcd_count_monitor.sv
// Directed checks for bcd_count_monitor: runs, wraps, direction flips, errors,
// saturation, clear priority and asynchronous reset.
module tb_bcd_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       x = 1'b1;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked, err, wrap_up, wrap_dn;
  logic [3:0] err_cnt, last;

  int checks = 0;
  int errors = 0;

  bcd_count_monitor dut (
    .clk(clk), .rst(rst), .bcd(bcd), .x(x), .en(en), .clr_err(clr_err),
    .locked(locked), .err(err), .err_cnt(err_cnt),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .last(last)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One edge: inputs applied at the falling edge, outputs settle 1ns after the rising edge.
  task automatic step(input logic [3:0] b, input logic xx, input logic e, input logic c);
    @(negedge clk);
    bcd = b; x = xx; en = e; clr_err = c;
    @(posedge clk);
    #1;
    $display("step bcd=%0d x=%0d en=%0d clr=%0d -> locked=%0d err=%0d cnt=%0d last=%0d wu=%0d wd=%0d",
             b, xx, e, c, locked, err, err_cnt, last, wrap_up, wrap_dn);
  endtask

  task automatic check_all_reset(input string tag);
    check_val({tag, "_locked"}, 8'(locked), 8'd0);
    check_val({tag, "_err"}, 8'(err), 8'd0);
    check_val({tag, "_cnt"}, 8'(err_cnt), 8'd0);
    check_val({tag, "_last"}, 8'(last), 8'd0);
    check_val({tag, "_wu"}, 8'(wrap_up), 8'd0);
    check_val({tag, "_wd"}, 8'(wrap_dn), 8'd0);
  endtask

  logic [3:0] up_seq [9] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
  logic [3:0] dn_seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};

  initial begin
    // Reset state
    #12;
    check_all_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    // Up run with a 9->0 wrap
    for (int i = 0; i < 9; i++) begin
      step(up_seq[i], 1'b1, 1'b1, 1'b0);
      check_val("up_locked", 8'(locked), 8'd1);
      check_val("up_last", 8'(last), 8'(up_seq[i]));
      check_val("up_wrap", 8'(wrap_up), (up_seq[i] == 4'd0) ? 8'd1 : 8'd0);
    end
    check_val("up_cnt", 8'(err_cnt), 8'd0);

    // en=0 gap: wrong value presented but not sampled
    step(4'd7, 1'b1, 1'b0, 1'b0);
    check_val("gap_locked", 8'(locked), 8'd1);
    check_val("gap_last", 8'(last), 8'd1);
    check_val("gap_err", 8'(err), 8'd0);

    // Down run with a 0->9 wrap
    step(4'd0, 1'b0, 1'b0, 1'b1);
    check_val("clr1_locked", 8'(locked), 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(dn_seq[i], 1'b0, 1'b1, 1'b0);
      check_val("dn_wrap", 8'(wrap_dn), (dn_seq[i] == 4'd9) ? 8'd1 : 8'd0);
      check_val("dn_wrap_up", 8'(wrap_up), 8'd0);
    end
    check_val("dn_last", 8'(last), 8'd8);
    check_val("dn_err", 8'(err), 8'd0);

    // Direction flip: 5 (up), 6 (down), 5
    step(4'd0, 1'b0, 1'b0, 1'b1);
    step(4'd5, 1'b1, 1'b1, 1'b0);
    step(4'd6, 1'b0, 1'b1, 1'b0);
    check_val("flip_locked6", 8'(locked), 8'd1);
    step(4'd5, 1'b0, 1'b1, 1'b0);
    check_val("flip_locked5", 8'(locked), 8'd1);
    check_val("flip_err", 8'(err), 8'd0);
    check_val("flip_last", 8'(last), 8'd5);

    // Skip then illegal code while in ERR
    step(4'd0, 1'b0, 1'b0, 1'b1);
    step(4'd3, 1'b1, 1'b1, 1'b0);
    step(4'd4, 1'b1, 1'b1, 1'b0);
    step(4'd6, 1'b1, 1'b1, 1'b0);
    check_val("skip_err", 8'(err), 8'd1);
    check_val("skip_locked", 8'(locked), 8'd0);
    check_val("skip_cnt", 8'(err_cnt), 8'd1);
    check_val("skip_last", 8'(last), 8'd4);
    step(4'd12, 1'b1, 1'b1, 1'b0);
    check_val("errign_cnt", 8'(err_cnt), 8'd1);
    check_val("errign_err", 8'(err), 8'd1);
    step(4'd5, 1'b1, 1'b1, 1'b0);
    check_val("errhold_err", 8'(err), 8'd1);
    check_val("errhold_last", 8'(last), 8'd4);
    step(4'd0, 1'b0, 1'b0, 1'b1);
    check_val("clr2_err", 8'(err), 8'd0);
    check_val("clr2_cnt", 8'(err_cnt), 8'd0);
    check_val("clr2_locked", 8'(locked), 8'd0);

    // Illegal codes in SYNC
    for (int i = 1; i <= 3; i++) begin
      step(4'd14, 1'b1, 1'b1, 1'b0);
      check_val("sync_ill_cnt", 8'(err_cnt), 8'(i));
      check_val("sync_ill_locked", 8'(locked), 8'd0);
      check_val("sync_ill_err", 8'(err), 8'd0);
    end
    step(4'd7, 1'b1, 1'b1, 1'b0);
    check_val("sync7_locked", 8'(locked), 8'd1);
    check_val("sync7_last", 8'(last), 8'd7);
    check_val("sync7_cnt", 8'(err_cnt), 8'd3);

    // clr_err wins over a simultaneous mismatching sample
    step(4'd2, 1'b1, 1'b1, 1'b1);
    check_val("clrpri_locked", 8'(locked), 8'd0);
    check_val("clrpri_err", 8'(err), 8'd0);
    check_val("clrpri_cnt", 8'(err_cnt), 8'd0);
    check_val("clrpri_last", 8'(last), 8'd7);

    // Saturation at 15
    for (int i = 1; i <= 17; i++) begin
      step(4'd10 + 4'(i % 6), 1'b1, 1'b1, 1'b0);
      check_val("sat_cnt", 8'(err_cnt), (i > 15) ? 8'd15 : 8'(i));
    end

    // Async reset during a wrap pulse
    step(4'd0, 1'b0, 1'b0, 1'b1);
    step(4'd9, 1'b1, 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b1, 1'b0);
    check_val("pre_rst_wrap", 8'(wrap_up), 8'd1);
    #1;
    en = 1'b0;
    rst = 1'b0;
    #1;
    check_all_reset("rst_wrap");
    @(negedge clk);
    rst = 1'b1;

    // Async reset while in ERR with a nonzero count
    step(4'd5, 1'b1, 1'b1, 1'b0);
    step(4'd5, 1'b1, 1'b1, 1'b0);
    check_val("pre_rst_err", 8'(err), 8'd1);
    check_val("pre_rst_cnt", 8'(err_cnt), 8'd1);
    #1;
    en = 1'b0;
    clr_err = 1'b0;
    rst = 1'b0;
    #1;
    check_all_reset("rst_err");
    @(negedge clk);
    rst = 1'b1;

    // First sample after reset is a SYNC sample
    step(4'd3, 1'b0, 1'b1, 1'b0);
    check_val("post_rst_locked", 8'(locked), 8'd1);
    check_val("post_rst_last", 8'(last), 8'd3);
    step(4'd2, 1'b0, 1'b1, 1'b0);
    check_val("post_rst_track", 8'(locked), 8'd1);
    check_val("post_rst_last2", 8'(last), 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
